// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding control for the 5-stage pipeline.
// Tracks destination tags through E/M/W and drives selectors, stalls and flushes.
module hazard_forward_unit #(
    parameter int REG_W    = 4,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] RA1D,
    input  logic [REG_W-1:0] RA2D,
    input  logic             useA_D,
    input  logic             useB_D,
    input  logic [REG_W-1:0] WA3D,
    input  logic             RegWriteD,
    input  logic             MemtoRegD,
    input  logic             branchTakenE,
    input  logic             memReadyM,
    output logic [1:0]       data1ForwardSelector,
    output logic [1:0]       data2ForwardSelector,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE
);

    typedef struct packed {
        logic [REG_W-1:0] ra1;
        logic [REG_W-1:0] ra2;
        logic             usea;
        logic             useb;
        logic [REG_W-1:0] wa;
        logic             rw;
        logic             ld;
    } ex_tag_t;

    typedef struct packed {
        logic [REG_W-1:0] wa;
        logic             rw;
    } wr_tag_t;

    ex_tag_t e_q, e_d;
    wr_tag_t m_q, w_q;

    logic mem_stall;
    logic lw_stall;
    logic flush_e;
    logic flush_d;
    logic stall_fd;

    function automatic logic valid_reg(input logic [REG_W-1:0] r);
        return !(ZERO_REG && (r == '0));
    endfunction

    // Memory stage holds the newest value, so it is checked first.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] ra,
        input logic             use_src,
        input wr_tag_t          m,
        input wr_tag_t          w
    );
        if (use_src && m.rw && valid_reg(m.wa) && (m.wa == ra))
            return 2'b10;
        else if (use_src && w.rw && valid_reg(w.wa) && (w.wa == ra))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        mem_stall = !memReadyM;
        lw_stall  = e_q.rw && e_q.ld && valid_reg(e_q.wa) &&
                    ((useA_D && (RA1D == e_q.wa)) ||
                     (useB_D && (RA2D == e_q.wa)));
        stall_fd  = mem_stall || (lw_stall && !branchTakenE);
        flush_d   = branchTakenE && !mem_stall;
        flush_e   = (lw_stall || branchTakenE) && !mem_stall;
    end

    always_comb begin
        e_d = '0;
        if (!flush_e) begin
            e_d.ra1  = RA1D;
            e_d.ra2  = RA2D;
            e_d.usea = useA_D;
            e_d.useb = useB_D;
            e_d.wa   = WA3D;
            e_d.rw   = RegWriteD;
            e_d.ld   = MemtoRegD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else if (!mem_stall) begin
            w_q <= m_q;
            m_q <= '{wa: e_q.wa, rw: e_q.rw};
            e_q <= e_d;
        end
    end

    // Controls are forced quiet while reset is held.
    always_comb begin
        data1ForwardSelector = fwd_sel(e_q.ra1, e_q.usea, m_q, w_q);
        data2ForwardSelector = fwd_sel(e_q.ra2, e_q.useb, m_q, w_q);
        stallF = stall_fd && !rst;
        stallD = stall_fd && !rst;
        stallE = mem_stall && !rst;
        stallM = mem_stall && !rst;
        flushD = flush_d && !rst;
        flushE = flush_e && !rst;
    end

endmodule
